piso_tx: RTL

- Parallel-in, serial-out transmitter; the sending end of the team's serial capture path.
- Accepts a WIDTH-bit word through a valid/ready handshake and emits it one bit per clock on dout.
- Provides a frame-enable strobe and a last-bit marker so a downstream latch or flop can capture each bit.
- Supports back-to-back words with no idle gap.

---
 rtl/piso_tx_pkg.sv | 20 ++
 rtl/piso_shift_reg.sv | 37 +++
 rtl/piso_tx.sv | 98 +++++++++
 3 files changed

// File: rtl/piso_tx_pkg.sv
// Shared definitions for the serial transmit/capture path: state encoding,
// counter sizing and the default word length used by both ends.
package piso_tx_pkg;

  localparam int DEFAULT_WIDTH = 8;

  localparam logic IDLE  = 1'b0;
  localparam logic SHIFT = 1'b1;

  typedef enum logic {
    ST_IDLE  = IDLE,
    ST_SHIFT = SHIFT
  } state_e;

  // Bit-counter width; never narrower than one bit.
  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/piso_shift_reg.sv
// WIDTH-bit zero-filling shift register with parallel load; head bit is a flop output.
// Load wins over shift; no backpressure (the owner decides when to load or shift).
module piso_shift_reg #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] load_dat,
  output logic             head
);

  logic [WIDTH-1:0] sr_q;
  logic [WIDTH-1:0] sr_d;

  always_comb begin
    sr_d = sr_q;
    if (load) begin
      sr_d = load_dat;
    end else if (shift_en) begin
      sr_d = MSB_FIRST ? {sr_q[WIDTH-2:0], 1'b0} : {1'b0, sr_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign head = MSB_FIRST ? sr_q[WIDTH-1] : sr_q[0];

endmodule

// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter: first bit one cycle after accept, WIDTH bits per frame.
// din_ready is high in IDLE or in the last-bit cycle, so back-to-back words run gap-free.
module piso_tx
  import piso_tx_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             dout,
  output logic             dout_en,
  output logic             dout_last,
  output logic             busy
);

  localparam int               CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e           state_q;
  state_e           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             load;
  logic             shift_en;
  logic             last_bit;
  logic             accept;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    load      = 1'b0;
    shift_en  = 1'b0;
    last_bit  = (state_q == ST_SHIFT) && (cnt_q == CNT_LAST);
    din_ready = (state_q == ST_IDLE) || last_bit;
    accept    = din_valid && din_ready;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          load    = 1'b1;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        // Shifting out the final bit leaves the zero-filled register empty,
        // which keeps dout low in IDLE without extra gating.
        if (accept) begin
          load  = 1'b1;
          cnt_d = '0;
        end else begin
          shift_en = 1'b1;
          if (last_bit) begin
            cnt_d   = '0;
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  piso_shift_reg #(
    .WIDTH    (WIDTH),
    .MSB_FIRST(MSB_FIRST)
  ) u_shift_reg (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .shift_en(shift_en),
    .load_dat(din),
    .head    (dout)
  );

  assign busy      = (state_q == ST_SHIFT);
  assign dout_en   = busy;
  assign dout_last = dout_en && (cnt_q == CNT_LAST);

endmodule
